// File: rtl/morse_round_ctrl.sv
// Morse trainer round sequencer: fetches a letter from the ROM, collects the player's
// dot/dash symbols under the response timer, judges the letter, and keeps score and lives.
module morse_round_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int NUM_WORDS = 16,
   parameter int CODE_W    = 5,
   parameter int LEN_W     = 3,
   parameter int SCORE_W   = 8,
   parameter int MAX_LIVES = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     symbol_valid,
   input  logic                     symbol_bit,
   input  logic                     letter_done,
   input  logic                     timeout,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [CODE_W+LEN_W-1:0]  rom_data,
   output logic                     timer_en,
   output logic                     timer_rst_n,
   output logic [SCORE_W-1:0]       score,
   output logic [2:0]               lives,
   output logic                     match,
   output logic                     miss,
   output logic                     busy,
   output logic                     game_over
);

   localparam int CNT_W = $clog2(CODE_W + 1);

   typedef enum logic [3:0] {
      IDLE, FETCH, LATCH, LISTEN, CHECK, HIT, MISS, NEXT, OVER
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_rom_addr;
   logic [CODE_W-1:0]   r_code;
   logic [CODE_W-1:0]   r_cap;
   logic [CNT_W-1:0]    r_len;
   logic [CNT_W-1:0]    r_sym_cnt;
   logic                r_ovf;
   logic                r_timer_en;
   logic                r_timer_rst_n;
   logic [SCORE_W-1:0]  r_score;
   logic [2:0]          r_lives;
   logic                r_match;
   logic                r_miss;
   logic                r_busy;
   logic                r_game_over;

   logic [LEN_W-1:0]    w_len_raw;
   logic [CNT_W-1:0]    w_len_eff;
   logic [CODE_W-1:0]   w_mask;
   logic                w_correct;

   // A zero or oversized length field means "use every code symbol".
   assign w_len_raw = rom_data[LEN_W-1:0];
   always_comb begin
      w_len_eff = CNT_W'(w_len_raw);
      if (w_len_raw == '0 || int'(w_len_raw) > CODE_W)
         w_len_eff = CNT_W'(CODE_W);
   end

   genvar gi;
   generate
      for (gi = 0; gi < CODE_W; gi++) begin : g_mask
         assign w_mask[gi] = (int'(r_len) > gi);
      end
   endgenerate

   assign w_correct = !r_ovf && (r_sym_cnt == r_len) && (((r_cap ^ r_code) & w_mask) == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_rom_addr    <= '0;
         r_code        <= '0;
         r_cap         <= '0;
         r_len         <= '0;
         r_sym_cnt     <= '0;
         r_ovf         <= 1'b0;
         r_timer_en    <= 1'b0;
         r_timer_rst_n <= 1'b1;
         r_score       <= '0;
         r_lives       <= '0;
         r_match       <= 1'b0;
         r_miss        <= 1'b0;
         r_busy        <= 1'b0;
         r_game_over   <= 1'b0;
      end else begin
         case (r_state)
            IDLE, OVER: begin
               if (start) begin
                  r_score     <= '0;
                  r_lives     <= 3'(MAX_LIVES);
                  r_rom_addr  <= '0;
                  r_busy      <= 1'b1;
                  r_game_over <= 1'b0;
                  r_state     <= FETCH;
               end
            end
            FETCH: begin
               r_timer_rst_n <= 1'b0;
               r_state       <= LATCH;
            end
            LATCH: begin
               r_code        <= rom_data[CODE_W+LEN_W-1:LEN_W];
               r_len         <= w_len_eff;
               r_cap         <= '0;
               r_sym_cnt     <= '0;
               r_ovf         <= 1'b0;
               r_timer_rst_n <= 1'b1;
               r_timer_en    <= 1'b1;
               r_state       <= LISTEN;
            end
            LISTEN: begin
               // A symbol arriving with letter_done is captured before CHECK judges it.
               if (symbol_valid) begin
                  if (int'(r_sym_cnt) < CODE_W) begin
                     r_cap[r_sym_cnt] <= symbol_bit;
                     r_sym_cnt        <= r_sym_cnt + 1'b1;
                  end else begin
                     r_ovf <= 1'b1;
                  end
               end
               if (letter_done) begin
                  r_timer_en <= 1'b0;
                  r_state    <= CHECK;
               end else if (timeout) begin
                  r_timer_en <= 1'b0;
                  r_miss     <= 1'b1;
                  if (r_lives != '0) r_lives <= r_lives - 1'b1;
                  r_state    <= MISS;
               end
            end
            CHECK: begin
               if (w_correct) begin
                  r_match <= 1'b1;
                  if (r_score != '1) r_score <= r_score + 1'b1;
                  r_state <= HIT;
               end else begin
                  r_miss  <= 1'b1;
                  if (r_lives != '0) r_lives <= r_lives - 1'b1;
                  r_state <= MISS;
               end
            end
            HIT: begin
               r_match <= 1'b0;
               r_state <= NEXT;
            end
            MISS: begin
               r_miss <= 1'b0;
               // Lives were already decremented on entry, so zero here means the last life went.
               if (r_lives == '0) begin
                  r_busy      <= 1'b0;
                  r_game_over <= 1'b1;
                  r_state     <= OVER;
               end else begin
                  r_state <= NEXT;
               end
            end
            NEXT: begin
               if (int'(r_rom_addr) == NUM_WORDS - 1) r_rom_addr <= '0;
               else                                  r_rom_addr <= r_rom_addr + 1'b1;
               r_state <= FETCH;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rom_addr    = r_rom_addr;
   assign timer_en    = r_timer_en;
   assign timer_rst_n = r_timer_rst_n;
   assign score       = r_score;
   assign lives       = r_lives;
   assign match       = r_match;
   assign miss        = r_miss;
   assign busy        = r_busy;
   assign game_over   = r_game_over;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Directed bench for morse_round_ctrl: a table of letter rounds through one game, then
// hand sequences for restart, a 16-letter wrap, and asynchronous reset mid-round.
module tb_morse_round_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       symbol_valid = 1'b0;
   logic       symbol_bit = 1'b0;
   logic       letter_done = 1'b0;
   logic       timeout = 1'b0;
   logic [3:0] rom_addr;
   logic [7:0] rom_data = 8'h00;
   logic       timer_en, timer_rst_n, match, miss, busy, game_over;
   logic [7:0] score;
   logic [2:0] lives;

   logic [7:0] rom [16];

   int n_checks = 0;
   int n_fail   = 0;

   morse_round_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .symbol_valid(symbol_valid),
      .symbol_bit(symbol_bit), .letter_done(letter_done), .timeout(timeout),
      .rom_addr(rom_addr), .rom_data(rom_data), .timer_en(timer_en),
      .timer_rst_n(timer_rst_n), .score(score), .lives(lives), .match(match),
      .miss(miss), .busy(busy), .game_over(game_over)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   typedef struct {
      int         n;
      logic [7:0] s;
      logic       d;
      logic       t;
      logic       pre_t;
      logic       e_match;
      int         e_score;
      int         e_lives;
      int         e_addr;
      logic       e_over;
   } vec_t;

   vec_t vt [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Entered one cycle after start or NEXT (state FETCH). Plays one letter and reports the verdict.
   task automatic play_round(input int n, input logic [7:0] s, input logic d, input logic t,
                             input logic pre_t, output logic gm, output logic gmiss,
                             output int lat, output int wt, output int rlows);
      wt = 0;
      rlows = 0;
      while (!timer_en && wt < 20) begin
         if (!timer_rst_n) rlows++;
         timeout = pre_t && !timer_rst_n;
         tick();
         wt++;
      end
      timeout = 1'b0;
      for (int i = 0; i < n; i++) begin
         symbol_valid = 1'b1;
         symbol_bit   = s[i];
         tick();
      end
      symbol_valid = 1'b0;
      letter_done  = d;
      timeout      = t;
      tick();
      letter_done = 1'b0;
      timeout     = 1'b0;
      lat = 1;
      while (!match && !miss && lat < 6) begin
         tick();
         lat++;
      end
      gm    = match;
      gmiss = miss;
   endtask

   initial begin
      logic gm, gmiss;
      int lat, wt, rlows, eff;
      logic [4:0] code;

      // Symbol i of a letter lives in code bit i, so "U" (dot dot dash) is 5'b00100.
      rom[0] = {5'b00100, 3'd3};
      rom[1] = {5'b10101, 3'd5};
      rom[2] = {5'b01101, 3'd0};
      rom[3] = {5'b00111, 3'd7};
      rom[4] = {5'b01011, 3'd4};
      rom[5] = {5'b11001, 3'd5};
      for (int i = 6; i < 16; i++) rom[i] = {5'(i), 3'((i % 5) + 1)};

      //          n  syms        done  tmo   pre_t match score lives addr over
      vt[0] = '{3, 8'b00000100, 1'b1, 1'b0, 1'b1, 1'b1, 1, 3, 1, 1'b0};
      vt[1] = '{5, 8'b00010101, 1'b1, 1'b1, 1'b0, 1'b1, 2, 3, 2, 1'b0};
      vt[2] = '{5, 8'b00001101, 1'b1, 1'b0, 1'b0, 1'b1, 3, 3, 3, 1'b0};
      vt[3] = '{3, 8'b00000111, 1'b1, 1'b0, 1'b0, 1'b0, 3, 2, 4, 1'b0};
      vt[4] = '{2, 8'b00000011, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1, 5, 1'b0};
      vt[5] = '{6, 8'b00111001, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0, 5, 1'b1};

      #12;
      chk("reset rom_addr", int'(rom_addr), 0);
      chk("reset score", int'(score), 0);
      chk("reset lives", int'(lives), 0);
      chk("reset timer_en", int'(timer_en), 0);
      chk("reset timer_rst_n", int'(timer_rst_n), 1);
      chk("reset busy/game_over/match/miss", int'({busy, game_over, match, miss}), 0);
      rst = 1'b1;
      tick();
      tick();

      do_start();
      chk("start busy", int'(busy), 1);
      chk("start lives", int'(lives), 3);
      for (int v = 0; v < 6; v++) begin
         play_round(vt[v].n, vt[v].s, vt[v].d, vt[v].t, vt[v].pre_t, gm, gmiss, lat, wt, rlows);
         chk($sformatf("v%0d start-to-listen", v), wt + 1, 3);
         chk($sformatf("v%0d timer_rst_n lows", v), rlows, 1);
         chk($sformatf("v%0d match", v), int'(gm), int'(vt[v].e_match));
         chk($sformatf("v%0d miss", v), int'(gmiss), int'(!vt[v].e_match));
         chk($sformatf("v%0d latency", v), lat, vt[v].d ? 2 : 1);
         chk($sformatf("v%0d score", v), int'(score), vt[v].e_score);
         chk($sformatf("v%0d lives", v), int'(lives), vt[v].e_lives);
         tick();
         tick();
         chk($sformatf("v%0d rom_addr", v), int'(rom_addr), vt[v].e_addr);
         chk($sformatf("v%0d game_over", v), int'(game_over), int'(vt[v].e_over));
         chk($sformatf("v%0d busy", v), int'(busy), int'(!vt[v].e_over));
      end
      chk("over timer_en", int'(timer_en), 0);
      letter_done = 1'b1;
      tick();
      letter_done = 1'b0;
      tick();
      chk("over ignores letter_done", int'({match, miss, game_over}), 1);

      // Restart from OVER, then the wrong-entry "U" case.
      do_start();
      chk("restart score", int'(score), 0);
      chk("restart lives", int'(lives), 3);
      chk("restart rom_addr", int'(rom_addr), 0);
      chk("restart game_over", int'(game_over), 0);
      play_round(3, 8'b00000110, 1'b1, 1'b0, 1'b0, gm, gmiss, lat, wt, rlows);
      chk("wrong U miss", int'({gm, gmiss}), 1);
      chk("wrong U lives", int'(lives), 2);
      chk("wrong U score", int'(score), 0);
      tick();
      tick();
      chk("wrong U rom_addr", int'(rom_addr), 1);

      // Sixteen correct letters: address wraps back to 0.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      do_start();
      for (int k = 0; k < 16; k++) begin
         code = rom[k][7:3];
         eff  = (rom[k][2:0] == 3'd0 || rom[k][2:0] > 3'd5) ? 5 : int'(rom[k][2:0]);
         play_round(eff, {3'b000, code}, 1'b1, 1'b0, 1'b0, gm, gmiss, lat, wt, rlows);
         chk($sformatf("run%0d match", k), int'({gm, gmiss}), 2);
         chk($sformatf("run%0d score", k), int'(score), k + 1);
         tick();
         tick();
      end
      chk("run rom_addr wrap", int'(rom_addr), 0);
      chk("run lives", int'(lives), 3);

      // Asynchronous reset in the middle of LISTEN.
      wt = 0;
      while (!timer_en && wt < 20) begin
         tick();
         wt++;
      end
      chk("pre-reset in listen", int'(timer_en), 1);
      symbol_valid = 1'b1;
      symbol_bit   = 1'b1;
      tick();
      symbol_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst timer_en", int'(timer_en), 0);
      chk("midrst timer_rst_n", int'(timer_rst_n), 1);
      chk("midrst score", int'(score), 0);
      chk("midrst lives", int'(lives), 0);
      chk("midrst rom_addr", int'(rom_addr), 0);
      chk("midrst flags", int'({busy, game_over, match, miss}), 0);
      tick();
      rst = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
